// File: rtl/bp_resolve.sv
// ---------------------------------------------------------------------------
// bp_resolve -- branch resolution and BTB training unit
//
// Fetch pushes every prediction it issues into an in-order FIFO. Execute
// resolves instructions oldest-first. On each resolution the head record is
// popped, and its predicted next PC is compared with the actual next PC. The
// result drives the BTB training strobe and the fetch redirect strobe.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   f_valid/f_ready  fetch push handshake; record is {f_pc, f_pred_valid,
//                    f_pred_target}
//   e_valid/e_ready  execute pop handshake; resolution is {e_is_branch,
//                    e_taken, e_target}
//   flush            synchronous pipeline flush
//   train, t_addr, t_paddr   registered BTB training port
//   redirect, redirect_pc    registered fetch redirect
//   count            FIFO occupancy
//   br_cnt, mp_cnt   saturating resolved-branch / mispredict counters
//   state            debug view of the FSM (0 = RUN, 1 = RECOVER)
//
// Handshakes: a transfer happens on a rising clk edge when valid && ready are
// both high. valid must not depend on ready. ready is combinational from
// state, occupancy and flush only, never from valid.
// ---------------------------------------------------------------------------
module bp_resolve #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     f_valid,
   output logic                     f_ready,
   input  logic [31:0]              f_pc,
   input  logic                     f_pred_valid,
   input  logic [31:0]              f_pred_target,
   input  logic                     e_valid,
   output logic                     e_ready,
   input  logic                     e_is_branch,
   input  logic                     e_taken,
   input  logic [31:0]              e_target,
   input  logic                     flush,
   output logic                     train,
   output logic [31:0]              t_addr,
   output logic [31:0]              t_paddr,
   output logic                     redirect,
   output logic [31:0]              redirect_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         br_cnt,
   output logic [CNT_W-1:0]         mp_cnt,
   output logic                     state
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_t;

   state_t cur_state, nxt_state;

   logic [31:0] pc_mem [DEPTH];
   logic        pv_mem [DEPTH];
   logic [31:0] pt_mem [DEPTH];

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0] wr_ptr, rd_ptr;
   logic        full, empty;
   logic        push, pop, eff_pop;

   logic [31:0] head_pc, head_pt;
   logic        head_pv;
   logic [31:0] pred_next, act_next;
   logic        mispredict, do_train;
   logic        squash;

   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;

   assign f_ready = !full && (cur_state == RUN) && !flush;
   assign e_ready = !empty;

   assign push    = f_valid && f_ready;
   assign pop     = e_valid && e_ready;
   // A flushed pop still leaves the FIFO, but it has no architectural effect.
   assign eff_pop = pop && !flush;

   assign head_pc = pc_mem[rd_ptr[AW-1:0]];
   assign head_pv = pv_mem[rd_ptr[AW-1:0]];
   assign head_pt = pt_mem[rd_ptr[AW-1:0]];

   assign pred_next  = head_pv ? head_pt : head_pc + 32'd4;
   assign act_next   = (e_is_branch && e_taken) ? e_target : head_pc + 32'd4;
   assign mispredict = (pred_next != act_next);
   assign do_train   = (e_is_branch && (e_taken || head_pv)) || (!e_is_branch && head_pv);

   // Everything still queued behind a mispredicted instruction is wrong-path.
   assign squash = flush || (eff_pop && mispredict);

   assign state = cur_state;

   // FSM: RECOVER lasts exactly one cycle after an accepted mispredict.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cur_state <= RUN;
      else      cur_state <= nxt_state;
   end

   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         RUN:     if (eff_pop && mispredict) nxt_state = RECOVER;
         RECOVER: nxt_state = RUN;
         default: nxt_state = RUN;
      endcase
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (squash) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO storage needs no reset; the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !squash) begin
         pc_mem[wr_ptr[AW-1:0]] <= f_pc;
         pv_mem[wr_ptr[AW-1:0]] <= f_pred_valid;
         pt_mem[wr_ptr[AW-1:0]] <= f_pred_target;
      end
   end

   // Registered training / redirect outputs; address fields hold when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         train       <= 1'b0;
         t_addr      <= '0;
         t_paddr     <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         train    <= eff_pop && do_train;
         redirect <= eff_pop && mispredict;
         if (eff_pop && do_train) begin
            t_addr  <= head_pc;
            t_paddr <= act_next;
         end
         if (eff_pop && mispredict) redirect_pc <= act_next;
      end
   end

   // Saturating statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         br_cnt <= '0;
         mp_cnt <= '0;
      end else begin
         if (eff_pop && e_is_branch && !(&br_cnt)) br_cnt <= br_cnt + 1'b1;
         if (eff_pop && mispredict && !(&mp_cnt))  mp_cnt <= mp_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_bp_resolve.sv
// ---------------------------------------------------------------------------
// tb_bp_resolve -- directed bench for bp_resolve.
// Counters are built 3 bits wide so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_bp_resolve;

   localparam int DEPTH = 8;
   localparam int CNT_W = 3;

   logic        clk;
   logic        rst;
   logic        f_valid, f_ready, f_pred_valid;
   logic [31:0] f_pc, f_pred_target;
   logic        e_valid, e_ready, e_is_branch, e_taken;
   logic [31:0] e_target;
   logic        flush;
   logic        train, redirect, state;
   logic [31:0] t_addr, t_paddr, redirect_pc;
   logic [$clog2(DEPTH):0] count;
   logic [CNT_W-1:0] br_cnt, mp_cnt;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   logic [31:0] pc;

   bp_resolve #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc),
      .f_pred_valid(f_pred_valid), .f_pred_target(f_pred_target),
      .e_valid(e_valid), .e_ready(e_ready), .e_is_branch(e_is_branch),
      .e_taken(e_taken), .e_target(e_target), .flush(flush),
      .train(train), .t_addr(t_addr), .t_paddr(t_paddr),
      .redirect(redirect), .redirect_pc(redirect_pc), .count(count),
      .br_cnt(br_cnt), .mp_cnt(mp_cnt), .state(state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_rec(input logic [31:0] p, input logic pv, input logic [31:0] pt);
      f_valid = 1'b1; f_pc = p; f_pred_valid = pv; f_pred_target = pt;
      tick();
      f_valid = 1'b0; f_pred_valid = 1'b0; f_pred_target = '0;
   endtask

   task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
      e_valid = 1'b1; e_is_branch = br; e_taken = tk; e_target = tgt;
      tick();
      e_valid = 1'b0; e_is_branch = 1'b0; e_taken = 1'b0; e_target = '0;
   endtask

   initial begin
      rst = 1'b0;
      f_valid = 0; f_pc = '0; f_pred_valid = 0; f_pred_target = '0;
      e_valid = 0; e_is_branch = 0; e_taken = 0; e_target = '0; flush = 0;
      #1;
      chk("rst_count",    32'(count), 32'd0);
      chk("rst_train",    32'(train), 32'd0);
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_br_cnt",   32'(br_cnt), 32'd0);
      chk("rst_e_ready",  32'(e_ready), 32'd0);
      chk("rst_rpc",      redirect_pc, 32'd0);
      tick(); tick();
      rst = 1'b1;
      #1;

      // reset in the middle of traffic, while a train pulse is high
      push_rec(32'h10, 1'b1, 32'h80);
      push_rec(32'h14, 1'b0, 32'h0);
      push_rec(32'h18, 1'b0, 32'h0);
      chk("mid_count3", 32'(count), 32'd3);
      resolve(1'b1, 1'b1, 32'h80);
      chk("mid_train", 32'(train), 32'd1);
      chk("mid_count2", 32'(count), 32'd2);
      chk("mid_br_cnt", 32'(br_cnt), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_train", 32'(train), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_br",    32'(br_cnt), 32'd0);
      chk("mid_rst_taddr", t_addr, 32'd0);
      chk("mid_rst_eready", 32'(e_ready), 32'd0);
      tick();
      rst = 1'b1;
      #1;
      chk("post_rst_fready", 32'(f_ready), 32'd1);
      chk("post_rst_eready", 32'(e_ready), 32'd0);

      // correct taken hit
      push_rec(32'h100, 1'b1, 32'h200);
      chk("hit_eready", 32'(e_ready), 32'd1);
      resolve(1'b1, 1'b1, 32'h200);
      chk("hit_train",    32'(train), 32'd1);
      chk("hit_taddr",    t_addr, 32'h100);
      chk("hit_tpaddr",   t_paddr, 32'h200);
      chk("hit_redirect", 32'(redirect), 32'd0);
      chk("hit_br",       32'(br_cnt), 32'd1);
      chk("hit_mp",       32'(mp_cnt), 32'd0);

      // missed taken branch, with a push in the same cycle that must be dropped
      push_rec(32'h104, 1'b0, 32'h0);
      push_rec(32'h108, 1'b0, 32'h0);
      f_valid = 1'b1; f_pc = 32'h10C;
      resolve(1'b1, 1'b1, 32'h400);
      f_valid = 1'b0;
      chk("miss_train",    32'(train), 32'd1);
      chk("miss_taddr",    t_addr, 32'h104);
      chk("miss_tpaddr",   t_paddr, 32'h400);
      chk("miss_redirect", 32'(redirect), 32'd1);
      chk("miss_rpc",      redirect_pc, 32'h400);
      chk("miss_count",    32'(count), 32'd0);
      chk("miss_fready",   32'(f_ready), 32'd0);
      chk("miss_state",    32'(state), 32'd1);
      chk("miss_mp",       32'(mp_cnt), 32'd1);
      chk("miss_br",       32'(br_cnt), 32'd2);
      tick();
      chk("rec_fready",   32'(f_ready), 32'd1);
      chk("rec_redirect", 32'(redirect), 32'd0);
      chk("rec_count",    32'(count), 32'd0);

      // false hit on a non-branch
      push_rec(32'h10C, 1'b1, 32'h300);
      resolve(1'b0, 1'b0, 32'h999);
      chk("fh_train",    32'(train), 32'd1);
      chk("fh_tpaddr",   t_paddr, 32'h110);
      chk("fh_redirect", 32'(redirect), 32'd1);
      chk("fh_rpc",      redirect_pc, 32'h110);
      chk("fh_br",       32'(br_cnt), 32'd2);
      chk("fh_mp",       32'(mp_cnt), 32'd2);
      tick();
      chk("hold_train", 32'(train), 32'd0);
      chk("hold_taddr", t_addr, 32'h10C);
      chk("hold_rpc",   redirect_pc, 32'h110);

      // fill to DEPTH
      for (int i = 0; i < DEPTH; i++) begin
         pc = 32'h1000 + 32'(4 * i);
         push_rec(pc, 1'b0, 32'h0);
         exp_q.push_back(pc);
      end
      chk("full_count",  32'(count), 32'(DEPTH));
      chk("full_fready", 32'(f_ready), 32'd0);

      // pop while full: the push offered in the same cycle is blocked
      f_valid = 1'b1; f_pc = 32'h1020;
      e_valid = 1'b1; e_is_branch = 1'b0; e_taken = 1'b0;
      #1;
      chk("full_pop_fready", 32'(f_ready), 32'd0);
      tick();
      void'(exp_q.pop_front());
      chk("full_pop_count", 32'(count), 32'(DEPTH - 1));

      // streaming push+pop across several pointer wraps
      for (int i = 0; i < 2 * DEPTH; i++) begin
         pc = 32'h1020 + 32'(4 * i);
         f_valid = 1'b1; f_pc = pc;
         e_valid = 1'b1; e_is_branch = 1'b0; e_taken = 1'b0;
         #1;
         chk("str_fready", 32'(f_ready), 32'd1);
         tick();
         exp_q.push_back(pc);
         void'(exp_q.pop_front());
         chk("str_count",    32'(count), 32'(DEPTH - 1));
         chk("str_train",    32'(train), 32'd0);
         chk("str_redirect", 32'(redirect), 32'd0);
      end
      f_valid = 1'b0;
      e_valid = 1'b0;

      // drain with correctly predicted taken-to-fallthrough branches so each
      // popped PC shows up on t_addr and the FIFO order can be checked
      for (int i = 0; i < DEPTH - 1; i++) begin
         exp_pc = exp_q.pop_front();
         resolve(1'b1, 1'b1, exp_pc + 32'd4);
         chk("drain_train",    32'(train), 32'd1);
         chk("drain_taddr",    t_addr, exp_pc);
         chk("drain_redirect", 32'(redirect), 32'd0);
      end
      chk("drain_count", 32'(count), 32'd0);
      chk("sat_br",      32'(br_cnt), 32'd7);
      chk("drain_mp",    32'(mp_cnt), 32'd2);

      // flush together with a mispredicting pop
      push_rec(32'h2000, 1'b0, 32'h0);
      push_rec(32'h2004, 1'b0, 32'h0);
      flush = 1'b1;
      #1;
      chk("fl_fready", 32'(f_ready), 32'd0);
      resolve(1'b1, 1'b1, 32'h5000);
      flush = 1'b0;
      #1;
      chk("fl_train",    32'(train), 32'd0);
      chk("fl_redirect", 32'(redirect), 32'd0);
      chk("fl_mp",       32'(mp_cnt), 32'd2);
      chk("fl_count",    32'(count), 32'd0);
      chk("fl_state",    32'(state), 32'd0);
      chk("fl_fready2",  32'(f_ready), 32'd1);

      // flush while in RECOVER
      push_rec(32'h3000, 1'b1, 32'h3100);
      resolve(1'b0, 1'b0, 32'h0);
      chk("rf_state1", 32'(state), 32'd1);
      chk("rf_rpc",    redirect_pc, 32'h3004);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("rf_state0", 32'(state), 32'd0);
      chk("rf_count",  32'(count), 32'd0);
      chk("rf_fready", 32'(f_ready), 32'd1);
      chk("rf_mp",     32'(mp_cnt), 32'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
